restoring_divider_ctl: RTL and testbench

- Sequential restoring divider: control FSM plus datapath. It is the divide counterpart of the team's shift-add multiplier.
- Driven by the same switch-style front end:
  - Din on the board switches.
  - LoadB loads the divisor.
  - Level-sensitive Run starts a divide.
- Quotient and remainder are held for display until the next operation.
- One shift step and one trial-subtract/restore step per quotient bit.

---
 rtl/restoring_divider_ctl.sv | 191 +++++++++++++++++++
 tb/tb_restoring_divider_ctl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_ctl.sv
// restoring_divider_ctl: sequential restoring divider (control FSM + datapath).
//
// Divides the dividend presented on Din at Start by the stored divisor. Each quotient
// bit takes one Shift cycle and one Sub (trial subtract / restore) cycle. Quotient and
// remainder stay on the outputs until the next Start.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      asynchronous, active-high; forces state R and clears all outputs
//   Run        level start request; one divide per high period
//   LoadB      load Din into the divisor register (only honoured in Idle)
//   Din        operand bus: divisor on LoadB, dividend on Start
//   Divisor    divisor register contents
//   Quotient   quotient register (shifts while busy)
//   Remainder  partial remainder, low WIDTH bits
//   Busy       high in Start, Shift, Sub and Fix
//   Done       high only in Done
//   DivZero    last completed operation had a zero divisor
//
// Build option: define SIGNED_DIV_EN for two's complement operands (truncating
// division, remainder takes the dividend's sign). Default build is unsigned; the Fix
// cycle exists in both builds so latency is identical.

module restoring_divider_ctl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             LoadB,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        StR,
        StIdle,
        StLoad,
        StStart,
        StShift,
        StSub,
        StFix,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q;
    logic [CntW-1:0]  cnt_q;
    logic             divzero_q;
    logic             busy_q;
    logic             done_q;

    logic             div_zero;
    logic [WIDTH-1:0] din_mag;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sub_t;

    assign div_zero = (divisor_q == '0);

`ifdef SIGNED_DIV_EN
    logic             din_neg;
    logic             div_neg;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] b_mag_q;
    logic             q_neg_q;
    logic             r_neg_q;

    assign din_neg = Din[WIDTH-1];
    assign div_neg = divisor_q[WIDTH-1];
    // Most-negative value maps onto itself, which reads correctly as an unsigned magnitude.
    assign din_mag = din_neg ? -Din : Din;
    assign div_mag = div_neg ? -divisor_q : divisor_q;
    assign b_op    = b_mag_q;
`else
    assign din_mag = Din;
    // Divisor cannot change while busy (LoadB only honoured in Idle), so use it directly.
    assign b_op    = divisor_q;
`endif

    // Borrow out in sub_t[WIDTH] means the trial subtract went negative.
    assign sub_t = a_q - {1'b0, b_op};

    always_comb begin
        state_d = state_q;
        case (state_q)
            StR:     state_d = StIdle;
            StIdle: begin
                if (Run) begin
                    state_d = StStart;
                end else if (LoadB) begin
                    state_d = StLoad;
                end
            end
            StLoad:  state_d = StIdle;
            StStart: state_d = div_zero ? StDone : StShift;
            StShift: state_d = StSub;
            StSub:   state_d = (cnt_q == '0) ? StFix : StShift;
            StFix:   state_d = StDone;
            StDone: begin
                if (!Run) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StR;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= StR;
            divisor_q <= '0;
            a_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            divzero_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SIGNED_DIV_EN
            b_mag_q   <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d inside {StStart, StShift, StSub, StFix});
            done_q  <= (state_d == StDone);

            case (state_q)
                StLoad: divisor_q <= Din;
                StStart: begin
                    divzero_q <= div_zero;
                    cnt_q     <= CntW'(WIDTH - 1);
                    if (div_zero) begin
                        // Divide-by-zero result: all-ones quotient, raw dividend as remainder.
                        q_q <= '1;
                        a_q <= {1'b0, Din};
                    end else begin
                        q_q <= din_mag;
                        a_q <= '0;
                    end
`ifdef SIGNED_DIV_EN
                    b_mag_q <= div_mag;
                    q_neg_q <= din_neg ^ div_neg;
                    r_neg_q <= din_neg;
`endif
                end
                StShift: begin
                    a_q <= {a_q[WIDTH-1:0], q_q[WIDTH-1]};
                    q_q <= {q_q[WIDTH-2:0], 1'b0};
                end
                StSub: begin
                    if (!sub_t[WIDTH]) begin
                        a_q    <= sub_t;
                        q_q[0] <= 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StFix: begin
`ifdef SIGNED_DIV_EN
                    if (q_neg_q) begin
                        q_q <= -q_q;
                    end
                    if (r_neg_q) begin
                        a_q <= {1'b0, -a_q[WIDTH-1:0]};
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign Divisor   = divisor_q;
    assign Quotient  = q_q;
    assign Remainder = a_q[WIDTH-1:0];
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivZero   = divzero_q;

endmodule

// File: tb/tb_restoring_divider_ctl.sv
// Bench for restoring_divider_ctl: directed and random divides checked through a
// scoreboard against plain-arithmetic expectations, plus reset and control checks.

module tb_restoring_divider_ctl;

    localparam int unsigned W      = 8;
    localparam int          LatDiv = 2 * W + 2;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         run   = 1'b0;
    logic         loadb = 1'b0;
    logic [W-1:0] din   = '0;

    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         divzero;

    restoring_divider_ctl #(
        .WIDTH(W)
    ) dut (
        .Clk      (clk),
        .Reset    (reset),
        .Run      (run),
        .LoadB    (loadb),
        .Din      (din),
        .Divisor  (divisor),
        .Quotient (quotient),
        .Remainder(remainder),
        .Busy     (busy),
        .Done     (done),
        .DivZero  (divzero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           n_checks  = 0;
    int           n_fail    = 0;
    logic [W-1:0] model_div = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division of the operands as the architecture defines them.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 1;
            return e;
        end
        e.dz  = 1'b0;
        e.lat = LatDiv;
`ifdef SIGNED_DIV_EN
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        // int arithmetic truncates toward zero; -128 / -1 = 128 wraps to 0x80 when narrowed.
        e.q = W'(sa / sbv);
        e.r = W'(sa % sbv);
`else
        sa  = int'(a);
        sbv = int'(b);
        e.q = W'(sa / sbv);
        e.r = W'(sa % sbv);
`endif
        return e;
    endfunction

    // Monitor: on every Done rising edge pop the oldest expectation and compare.
    initial begin : monitor
        logic done_prev;
        logic busy_prev;
        int   busy_cnt;
        exp_t e;
        done_prev = 1'b0;
        busy_prev = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (busy) begin
                busy_cnt = busy_prev ? busy_cnt + 1 : 1;
            end
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", 32'(quotient), 32'(e.q));
                    check("remainder", 32'(remainder), 32'(e.r));
                    check("divzero", 32'(divzero), 32'(e.dz));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
                end
            end
            done_prev = done;
            busy_prev = busy;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_divisor"}, 32'(divisor), 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'd0);
        check({tag, "_remainder"}, 32'(remainder), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_divzero"}, 32'(divzero), 32'd0);
    endtask

    // Called at posedge+1 with the FSM in Idle; returns the same way.
    task automatic load_div(input logic [W-1:0] d);
        din   = d;
        loadb = 1'b1;
        @(posedge clk);
        #1;
        loadb = 1'b0;
        @(posedge clk);
        #1;
        model_div = d;
        check("divisor_load", 32'(divisor), 32'(d));
    endtask

    task automatic wait_done();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            got = done;
        end
        check("done_within_bound", 32'(done), 32'd1);
        if (!got && sb.size() != 0) begin
            void'(sb.pop_front());
        end
    endtask

    task automatic run_op(input logic [W-1:0] x);
        sb.push_back(model(x, model_div));
        din = x;
        run = 1'b1;
        wait_done();
        run = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset behaviour
        #1 reset = 1'b1;
        #2;
        check_all_zero("in_reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("r_cycle");
        @(posedge clk);
        #1;

        // Directed unsigned cases
        load_div(8'd7);
        run_op(8'd200);
        load_div(8'd200);
        run_op(8'd7);
        load_div(8'd1);
        run_op(8'd255);
        load_div(8'd0);
        run_op(8'h5A);
        load_div(8'd13);
        run_op(8'd13);

`ifdef SIGNED_DIV_EN
        load_div(8'd7);
        run_op(8'h9C);
        load_div(8'hFF);
        run_op(8'h80);
        load_div(8'hF9);
        run_op(8'd100);
`endif

        // Run held high: one divide only; LoadB while busy is ignored.
        load_div(8'd5);
        sb.push_back(model(8'd100, model_div));
        din = 8'd100;
        run = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        din   = 8'h33;
        loadb = 1'b1;
        @(posedge clk);
        #1;
        loadb = 1'b0;
        wait_done();
        loadb = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        loadb = 1'b0;
        check("held_done", 32'(done), 32'd1);
        check("held_busy", 32'(busy), 32'd0);
        check("held_divisor", 32'(divisor), 32'd5);
        run = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_run_low", 32'(done), 32'd0);

        // Random divides
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                load_div('0);
            end else begin
                load_div(W'($urandom));
            end
            run_op(W'($urandom));
        end

        // Reset during Sub step 5 aborts the divide.
        load_div(8'd3);
        din = 8'hC8;
        run = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2;
        check("busy_before_abort", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        run = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        model_div = '0;
        @(negedge clk);
        check("abort_r_busy", 32'(busy), 32'd0);
        repeat (25) @(posedge clk);
        #1;
        check("abort_divisor", 32'(divisor), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);

        // Recovery after abort
        load_div(8'd3);
        run_op(8'd100);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
